// File: rtl/pulse_stat_window.sv
// Per-pulse discharge classifier with windowed rate statistics.
// Rates are floor(count*100/WINDOW_PULSES) from a serial restoring divider.
module pulse_stat_window #(
  parameter int DATA_W        = 16,
  parameter int V_OPEN        = 60,
  parameter int V_SHORT       = 5,
  parameter int I_DISCHARGE   = 5,
  parameter int NORMAL_DELAY  = 10,
  parameter int WINDOW_PULSES = 100,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_current,
  input  logic [DATA_W-1:0] sample_voltage,
  input  logic              is_machine,
  input  logic              stat_clear,
  input  logic              feedback_finished,
  output logic [7:0]        normal_rate,
  output logic [7:0]        arc_rate,
  output logic [7:0]        open_rate,
  output logic [7:0]        short_rate,
  output logic              rates_valid,
  output logic              rates_overrun,
  output logic              busy
);

  localparam int DW    = CNT_W + 7;
  localparam int ITERS = CNT_W + 7;
  localparam int IT_W  = $clog2(ITERS + 1);

  localparam logic [CNT_W-1:0]  ND   = CNT_W'(NORMAL_DELAY);
  localparam logic [CNT_W-1:0]  WP   = CNT_W'(WINDOW_PULSES);
  localparam logic [CNT_W-1:0]  WP_L = CNT_W'(WINDOW_PULSES - 1);
  localparam logic [DATA_W-1:0] I_TH = DATA_W'(I_DISCHARGE);
  localparam logic [DATA_W-1:0] V_SH = DATA_W'(V_SHORT);
  localparam logic [IT_W-1:0]   IT_L = IT_W'(ITERS - 1);

  if (WINDOW_PULSES < 1 || V_OPEN <= V_SHORT) begin : g_bad_param
    $error("pulse_stat_window: illegal parameter set");
  end

  typedef enum logic {IDLE, ON} st_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction

  st_t               state;
  logic              prev_m;
  logic [CNT_W-1:0]  dly;
  logic [CNT_W-1:0]  bd_dly;
  logic              bd_seen;
  logic [DATA_W-1:0] bd_v;

  logic rise, fall, hit;
  logic classify, last, drop;
  logic c_n, c_a, c_o, c_s;

  assign rise = is_machine & ~prev_m;
  assign fall = (state == ON) & ~is_machine;
  assign hit  = sample_current > I_TH;

  assign classify = fall & ~stat_clear;
  assign c_o = ~bd_seen;
  assign c_s = bd_seen & (bd_v < V_SH);
  assign c_a = bd_seen & ~(bd_v < V_SH) & (bd_dly < ND);
  assign c_n = bd_seen & ~(bd_v < V_SH) & ~(bd_dly < ND);

  // prev_m resets high so a pulse already on at release is never seen rising
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev_m  <= 1'b1;
      dly     <= '0;
      bd_seen <= 1'b0;
      bd_dly  <= '0;
      bd_v    <= '0;
    end else begin
      prev_m <= is_machine;
      if (stat_clear) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              state   <= ON;
              dly     <= (ND == '0) ? '0 : CNT_W'(1);
              bd_seen <= hit;
              bd_dly  <= '0;
              bd_v    <= sample_voltage;
            end
          end
          ON: begin
            if (!is_machine) begin
              state <= IDLE;
            end else begin
              if (dly != ND) dly <= dly + 1'b1;
              if (hit && !bd_seen) begin
                bd_seen <= 1'b1;
                bd_dly  <= dly;
                bd_v    <= sample_voltage;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [CNT_W-1:0] cnt_n, cnt_a, cnt_o, cnt_s, total;
  logic [CNT_W-1:0] nx_n, nx_a, nx_o, nx_s;

  assign nx_n = sat_inc(cnt_n, c_n);
  assign nx_a = sat_inc(cnt_a, c_a);
  assign nx_o = sat_inc(cnt_o, c_o);
  assign nx_s = sat_inc(cnt_s, c_s);
  assign last = classify & (total == WP_L);
  assign drop = last & busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_n <= '0;
      cnt_a <= '0;
      cnt_o <= '0;
      cnt_s <= '0;
      total <= '0;
    end else if (stat_clear || last) begin
      cnt_n <= '0;
      cnt_a <= '0;
      cnt_o <= '0;
      cnt_s <= '0;
      total <= '0;
    end else if (classify) begin
      cnt_n <= nx_n;
      cnt_a <= nx_a;
      cnt_o <= nx_o;
      cnt_s <= nx_s;
      total <= total + 1'b1;
    end
  end

  logic [CNT_W-1:0] snap [4];
  logic [1:0]       cls;
  logic [IT_W-1:0]  it;
  logic             ld;
  logic [DW-1:0]    q, q_nx, dvd;
  logic [CNT_W-1:0] r, r_nx;
  logic [CNT_W:0]   r_sh;
  logic             ge;
  logic [7:0]       res0, res1, res2;
  logic             latch;

  assign dvd   = DW'(snap[cls]) * DW'(100);
  assign r_sh  = {r, q[DW-1]};
  assign ge    = r_sh >= {1'b0, WP};
  assign r_nx  = ge ? CNT_W'(r_sh - {1'b0, WP}) : r_sh[CNT_W-1:0];
  assign q_nx  = {q[DW-2:0], ge};
  assign latch = busy & ~ld & (it == IT_L) & (cls == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) snap[k] <= '0;
      busy          <= 1'b0;
      cls           <= '0;
      it            <= '0;
      ld            <= 1'b0;
      q             <= '0;
      r             <= '0;
      res0          <= '0;
      res1          <= '0;
      res2          <= '0;
      normal_rate   <= '0;
      arc_rate      <= '0;
      open_rate     <= '0;
      short_rate    <= '0;
      rates_valid   <= 1'b0;
      rates_overrun <= 1'b0;
    end else begin
      if (last && !busy) begin
        snap[0] <= nx_n;
        snap[1] <= nx_a;
        snap[2] <= nx_o;
        snap[3] <= nx_s;
        busy    <= 1'b1;
        ld      <= 1'b1;
        cls     <= '0;
      end else if (busy) begin
        if (ld) begin
          q  <= dvd;
          r  <= '0;
          it <= '0;
          ld <= 1'b0;
        end else begin
          q <= q_nx;
          r <= r_nx;
          if (it == IT_L) begin
            unique case (cls)
              2'd0: res0 <= q_nx[7:0];
              2'd1: res1 <= q_nx[7:0];
              2'd2: res2 <= q_nx[7:0];
              default: begin
                normal_rate <= res0;
                arc_rate    <= res1;
                open_rate   <= res2;
                short_rate  <= q_nx[7:0];
                busy        <= 1'b0;
              end
            endcase
            cls <= cls + 1'b1;
            ld  <= 1'b1;
          end else begin
            it <= it + 1'b1;
          end
        end
      end

      if (latch) begin
        rates_valid <= 1'b1;
        if (rates_valid && !feedback_finished) rates_overrun <= 1'b1;
      end else if (feedback_finished && rates_valid) begin
        rates_valid   <= 1'b0;
        rates_overrun <= 1'b0;
      end
      if (drop) rates_overrun <= 1'b1;
    end
  end

endmodule
